// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the five-stage core.
// FSM encoding and hazard-unit defaults.
package pipeline_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_IRQ_SVC = 1'b1
  } hz_state_t;

  localparam int MD_LAT_DEF = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div busy tracker: reloads when an MD op sits in EX,
// then counts down to zero.
module md_busy_counter #(
  parameter int MD_LAT = pipeline_pkg::MD_LAT_DEF,
  parameter int CNT_W  = $clog2(MD_LAT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(MD_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = load | (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing control: load-use, mult/div wait,
// branch/jump squash and interrupt entry/exit.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = $clog2(MD_LAT + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_use_rs,
  input  logic       ID_use_rt,
  input  logic       ID_valid,
  input  logic       ID_jump,
  input  logic       ID_md,
  input  logic       ID_mfhilo,
  input  logic       ID_eret,
  input  logic       EX_MemRd,
  input  logic       EX_RegWr,
  input  logic [4:0] EX_WrReg,
  input  logic       EX_md,
  input  logic       EX_branch,
  input  logic       irq,
  output logic       PC_hold,
  output logic       IFID_hold,
  output logic       IFID_flush,
  output logic       IDEX_stall,
  output logic       irq_ack,
  output logic       md_busy,
  output logic       in_isr
);

  hz_state_t state;
  logic      md_busy_raw;
  logic      lu;
  logic      mds;
  logic      stall;
  logic      take_irq;
  logic      take_eret;

  md_busy_counter #(
    .MD_LAT(MD_LAT),
    .CNT_W (CNT_W)
  ) u_md_cnt (
    .clk  (clk),
    .reset(reset),
    .load (EX_md),
    .busy (md_busy_raw)
  );

  assign lu = EX_MemRd & EX_RegWr
            & (EX_WrReg != REG_ZERO)
            & ((ID_use_rs & (ID_rs == EX_WrReg))
             | (ID_use_rt & (ID_rt == EX_WrReg)));

  assign mds   = md_busy_raw & (ID_mfhilo | ID_md);
  assign stall = lu | mds;

  assign take_irq = (state == ST_RUN) & irq & ID_valid
                  & ~stall & ~EX_branch;
  assign take_eret = (state == ST_IRQ_SVC) & ID_eret
                   & ~stall & ~EX_branch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      unique case (1'b1)
        take_irq:  state <= ST_IRQ_SVC;
        take_eret: state <= ST_RUN;
        default:   state <= state;
      endcase
    end
  end

  assign md_busy = reset & md_busy_raw;
  assign in_isr  = reset & (state == ST_IRQ_SVC);

  // Reset outranks branch, which outranks stall and irq entry.
  always_comb begin
    PC_hold    = 1'b0;
    IFID_hold  = 1'b0;
    IFID_flush = 1'b0;
    IDEX_stall = 1'b0;
    irq_ack    = 1'b0;
    if (!reset || EX_branch) begin
      IFID_flush = 1'b1;
      IDEX_stall = 1'b1;
    end else if (stall) begin
      PC_hold    = 1'b1;
      IFID_hold  = 1'b1;
      IDEX_stall = 1'b1;
    end else begin
      if (ID_jump) IFID_flush = 1'b1;
      if (take_irq) begin
        irq_ack    = 1'b1;
        IFID_flush = 1'b1;
        IDEX_stall = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MD_LAT=4.
// Outputs packed as {PC_hold,IFID_hold,IFID_flush,IDEX_stall,irq_ack,md_busy,in_isr}.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_rs, ID_rt, EX_WrReg;
  logic       ID_use_rs, ID_use_rt, ID_valid, ID_jump;
  logic       ID_md, ID_mfhilo, ID_eret;
  logic       EX_MemRd, EX_RegWr, EX_md, EX_branch, irq;
  logic       PC_hold, IFID_hold, IFID_flush, IDEX_stall;
  logic       irq_ack, md_busy, in_isr;
  logic [6:0] outs;
  int         n_chk = 0;
  int         n_fail = 0;

  assign outs = {PC_hold, IFID_hold, IFID_flush, IDEX_stall,
                 irq_ack, md_busy, in_isr};

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LAT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ID_rs     (ID_rs),
    .ID_rt     (ID_rt),
    .ID_use_rs (ID_use_rs),
    .ID_use_rt (ID_use_rt),
    .ID_valid  (ID_valid),
    .ID_jump   (ID_jump),
    .ID_md     (ID_md),
    .ID_mfhilo (ID_mfhilo),
    .ID_eret   (ID_eret),
    .EX_MemRd  (EX_MemRd),
    .EX_RegWr  (EX_RegWr),
    .EX_WrReg  (EX_WrReg),
    .EX_md     (EX_md),
    .EX_branch (EX_branch),
    .irq       (irq),
    .PC_hold   (PC_hold),
    .IFID_hold (IFID_hold),
    .IFID_flush(IFID_flush),
    .IDEX_stall(IDEX_stall),
    .irq_ack   (irq_ack),
    .md_busy   (md_busy),
    .in_isr    (in_isr)
  );

  task automatic idle();
    ID_rs = 5'd0; ID_rt = 5'd0; EX_WrReg = 5'd0;
    ID_use_rs = 0; ID_use_rt = 0; ID_valid = 0;
    ID_jump = 0; ID_md = 0; ID_mfhilo = 0; ID_eret = 0;
    EX_MemRd = 0; EX_RegWr = 0; EX_md = 0;
    EX_branch = 0; irq = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    @(negedge clk);
    #1;
    n_chk++;
    if (outs !== 7'b0011000) begin
      n_fail++;
      $display("FAIL reset_held got=%b exp=%b", outs, 7'b0011000);
    end
    EX_md = 1'b1;
    #1;
    n_chk++;
    if (outs !== 7'b0011000) begin
      n_fail++;
      $display("FAIL reset_md_mask got=%b exp=%b", outs, 7'b0011000);
    end
    EX_md = 1'b0;
    reset = 1'b1;
    step();
    #1;
    n_chk++;
    if (outs !== 7'b0000000) begin
      n_fail++;
      $display("FAIL reset_release got=%b exp=%b", outs, 7'b0000000);
    end
  endtask

  task automatic test_load_use();
    idle();
    ID_valid = 1; EX_MemRd = 1; EX_RegWr = 1; EX_WrReg = 5'd5;
    ID_rs = 5'd5; ID_use_rs = 1;
    #1;
    n_chk++;
    if (outs !== 7'b1101000) begin
      n_fail++;
      $display("FAIL lu_rs got=%b exp=%b", outs, 7'b1101000);
    end
    step();
    EX_MemRd = 0; EX_RegWr = 0; EX_WrReg = 5'd0;
    #1;
    n_chk++;
    if (outs !== 7'b0000000) begin
      n_fail++;
      $display("FAIL lu_release got=%b exp=%b", outs, 7'b0000000);
    end
    step();
    EX_MemRd = 1; EX_RegWr = 1; EX_WrReg = 5'd0; ID_rs = 5'd0;
    #1;
    n_chk++;
    if (outs !== 7'b0000000) begin
      n_fail++;
      $display("FAIL lu_r0 got=%b exp=%b", outs, 7'b0000000);
    end
    EX_WrReg = 5'd9; ID_rs = 5'd1; ID_rt = 5'd9; ID_use_rt = 1;
    #1;
    n_chk++;
    if (outs !== 7'b1101000) begin
      n_fail++;
      $display("FAIL lu_rt got=%b exp=%b", outs, 7'b1101000);
    end
    ID_use_rt = 0;
    #1;
    n_chk++;
    if (outs !== 7'b0000000) begin
      n_fail++;
      $display("FAIL lu_rt_unused got=%b exp=%b", outs, 7'b0000000);
    end
    EX_RegWr = 0; ID_use_rt = 1;
    #1;
    n_chk++;
    if (outs !== 7'b0000000) begin
      n_fail++;
      $display("FAIL lu_noregwr got=%b exp=%b", outs, 7'b0000000);
    end
    idle();
    step();
  endtask

  task automatic test_md_wait();
    idle();
    ID_valid = 1; EX_md = 1; ID_mfhilo = 1;
    #1;
    n_chk++;
    if (outs !== 7'b1101010) begin
      n_fail++;
      $display("FAIL md_ex got=%b exp=%b", outs, 7'b1101010);
    end
    step();
    EX_md = 0;
    for (int i = 4; i >= 1; i--) begin
      #1;
      n_chk++;
      if (outs !== 7'b1101010) begin
        n_fail++;
        $display("FAIL md_cnt%0d got=%b exp=%b", i, outs, 7'b1101010);
      end
      step();
    end
    #1;
    n_chk++;
    if (outs !== 7'b0000000) begin
      n_fail++;
      $display("FAIL md_release got=%b exp=%b", outs, 7'b0000000);
    end
    ID_mfhilo = 0; EX_md = 1; ID_md = 1;
    #1;
    n_chk++;
    if (outs !== 7'b1101010) begin
      n_fail++;
      $display("FAIL md_struct got=%b exp=%b", outs, 7'b1101010);
    end
    ID_md = 0;
    #1;
    n_chk++;
    if (outs !== 7'b0000010) begin
      n_fail++;
      $display("FAIL md_nouse got=%b exp=%b", outs, 7'b0000010);
    end
    idle();
    repeat (6) step();
  endtask

  task automatic test_branch_jump();
    idle();
    ID_valid = 1; EX_MemRd = 1; EX_RegWr = 1; EX_WrReg = 5'd7;
    ID_rs = 5'd7; ID_use_rs = 1; EX_branch = 1;
    #1;
    n_chk++;
    if (outs !== 7'b0011000) begin
      n_fail++;
      $display("FAIL br_over_lu got=%b exp=%b", outs, 7'b0011000);
    end
    EX_branch = 0; ID_jump = 1;
    #1;
    n_chk++;
    if (outs !== 7'b1101000) begin
      n_fail++;
      $display("FAIL jump_stalled got=%b exp=%b", outs, 7'b1101000);
    end
    step();
    EX_MemRd = 0; EX_RegWr = 0; EX_WrReg = 5'd0;
    #1;
    n_chk++;
    if (outs !== 7'b0010000) begin
      n_fail++;
      $display("FAIL jump_flush got=%b exp=%b", outs, 7'b0010000);
    end
    idle();
    step();
  endtask

  task automatic test_irq();
    idle();
    ID_valid = 1; irq = 1;
    #1;
    n_chk++;
    if (outs !== 7'b0011100) begin
      n_fail++;
      $display("FAIL irq_ack got=%b exp=%b", outs, 7'b0011100);
    end
    step();
    for (int i = 0; i < 10; i++) begin
      #1;
      n_chk++;
      if (outs !== 7'b0000001) begin
        n_fail++;
        $display("FAIL irq_held%0d got=%b exp=%b", i, outs, 7'b0000001);
      end
      step();
    end
    ID_eret = 1;
    #1;
    n_chk++;
    if (outs !== 7'b0000001) begin
      n_fail++;
      $display("FAIL eret_cycle got=%b exp=%b", outs, 7'b0000001);
    end
    step();
    ID_eret = 0;
    #1;
    n_chk++;
    if (outs !== 7'b0011100) begin
      n_fail++;
      $display("FAIL irq_reack got=%b exp=%b", outs, 7'b0011100);
    end
    step();
    irq = 0; ID_eret = 1;
    #1;
    n_chk++;
    if (outs !== 7'b0000001) begin
      n_fail++;
      $display("FAIL isr_again got=%b exp=%b", outs, 7'b0000001);
    end
    step();
    idle();
  endtask

  task automatic test_irq_blocked();
    idle();
    ID_valid = 1; irq = 1; EX_branch = 1;
    #1;
    n_chk++;
    if (outs !== 7'b0011000) begin
      n_fail++;
      $display("FAIL irq_vs_br got=%b exp=%b", outs, 7'b0011000);
    end
    step();
    EX_branch = 0;
    #1;
    n_chk++;
    if (outs !== 7'b0011100) begin
      n_fail++;
      $display("FAIL irq_after_br got=%b exp=%b", outs, 7'b0011100);
    end
    step();
    irq = 0; ID_eret = 1; EX_branch = 1;
    step();
    EX_branch = 0; ID_eret = 0;
    #1;
    n_chk++;
    if (outs !== 7'b0000001) begin
      n_fail++;
      $display("FAIL eret_squashed got=%b exp=%b", outs, 7'b0000001);
    end
    ID_eret = 1;
    step();
    idle();
    ID_valid = 1; irq = 1; EX_md = 1; ID_mfhilo = 1;
    #1;
    n_chk++;
    if (outs !== 7'b1101010) begin
      n_fail++;
      $display("FAIL irq_vs_md got=%b exp=%b", outs, 7'b1101010);
    end
    step();
    EX_md = 0;
    for (int i = 4; i >= 1; i--) begin
      #1;
      n_chk++;
      if (outs !== 7'b1101010) begin
        n_fail++;
        $display("FAIL irq_md_cnt%0d got=%b exp=%b", i, outs, 7'b1101010);
      end
      step();
    end
    #1;
    n_chk++;
    if (outs !== 7'b0011100) begin
      n_fail++;
      $display("FAIL irq_after_md got=%b exp=%b", outs, 7'b0011100);
    end
    step();
    idle();
    ID_eret = 1;
    step();
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    ID_valid = 1; irq = 1;
    step();
    irq = 0; EX_md = 1;
    step();
    EX_md = 0;
    step();
    #1;
    n_chk++;
    if (outs !== 7'b0000011) begin
      n_fail++;
      $display("FAIL pre_reset got=%b exp=%b", outs, 7'b0000011);
    end
    reset = 1'b0;
    #1;
    n_chk++;
    if (outs !== 7'b0011000) begin
      n_fail++;
      $display("FAIL async_reset got=%b exp=%b", outs, 7'b0011000);
    end
    #1;
    reset = 1'b1;
    #1;
    n_chk++;
    if (outs !== 7'b0000000) begin
      n_fail++;
      $display("FAIL post_reset got=%b exp=%b", outs, 7'b0000000);
    end
    step();
    ID_mfhilo = 1;
    #1;
    n_chk++;
    if (outs !== 7'b0000000) begin
      n_fail++;
      $display("FAIL cnt_cleared got=%b exp=%b", outs, 7'b0000000);
    end
    ID_mfhilo = 0; irq = 1;
    #1;
    n_chk++;
    if (outs !== 7'b0011100) begin
      n_fail++;
      $display("FAIL run_after_rst got=%b exp=%b", outs, 7'b0011100);
    end
    step();
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_md_wait();
    test_branch_jump();
    test_irq();
    test_irq_blocked();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage MIPS core. It drives the hold, flush and bubble controls of the PC, IF/ID and ID/EX pipeline registers. It detects load-use hazards and tracks the multi-cycle mult/div unit so that HI/LO readers wait for it. It also sequences taken-branch and jump squashes and interrupt entry/exit.

## Interface
Parameters:
- MD_LAT, 32, cycles the mult/div unit stays busy after an MD op leaves EX (≥1)
- CNT_W, $clog2(MD_LAT+1), busy counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- ID_rs, ID_rt  in  5  source register fields of the instruction in ID
- ID_use_rs, ID_use_rt  in  1  ID instruction actually reads rs / rt
- ID_valid  in  1  ID holds a real (non-bubble) instruction
- ID_jump  in  1  j/jal/jr resolved in ID
- ID_md  in  1  ID holds mult/div
- ID_mfhilo  in  1  ID holds mfhi/mflo
- ID_eret  in  1  ID holds eret
- EX_MemRd, EX_RegWr  in  1  EX-stage control bits
- EX_WrReg  in  5  EX destination register
- EX_md  in  1  EX holds mult/div
- EX_branch  in  1  branch in EX resolved taken
- irq  in  1  level interrupt request
- PC_hold  out  1  PC keeps its value
- IFID_hold  out  1  IF/ID keeps its contents
- IFID_flush  out  1  IF/ID loads a bubble
- IDEX_stall  out  1  ID/EX loads a bubble (MemWr/MemRd/RegWr forced 0)
- irq_ack  out  1  interrupt accepted this cycle; PC takes the vector and EPC captures ID_PC
- md_busy  out  1  mult/div result not yet available
- in_isr  out  1  FSM is in IRQ_SVC

## Operation
- Hazard outputs are combinational from the inputs plus registered state. The registered state is the FSM and the busy counter.
- Load-use: lu = EX_MemRd & EX_RegWr & (EX_WrReg≠0) & ((ID_use_rs & ID_rs==EX_WrReg) | (ID_use_rt & ID_rt==EX_WrReg)).
- MD busy: md_busy = EX_md | (cnt≠0).
  - Counter update on each edge: if EX_md, cnt ← MD_LAT; else if cnt≠0, cnt ← cnt−1.
- MD stall: mds = md_busy & (ID_mfhilo | ID_md). A second MD op is structurally stalled.
- stall = lu | mds. When stall is asserted: PC_hold=1, IFID_hold=1, IDEX_stall=1, IFID_flush=0.
- ID_jump with no stall: IFID_flush=1 (squashes the fetched wrong-path instruction). A jump that is stalled waits; no flush occurs until the stall clears.
- EX_branch has the highest priority after reset.
  - Outputs: IFID_flush=1, IDEX_stall=1, PC_hold=0, IFID_hold=0.
  - It overrides stall, ID_jump, ID_eret and irq acceptance.
  - The counter still updates normally.
- FSM states:
  - RUN: if irq & ID_valid & ~stall & ~EX_branch, then irq_ack=1, IFID_flush=1, IDEX_stall=1, PC_hold=0, and the next state is IRQ_SVC.
  - IRQ_SVC: irq is ignored. If ID_eret & ~stall & ~EX_branch, the next state is RUN. An eret squashed by a branch does not count.
- Idle defaults for all outputs are 0, except md_busy and in_isr, which follow their definitions.

## Timing
- Reset asserted, asynchronously: FSM=RUN, cnt=0.
  - While reset is low, outputs are forced to IFID_flush=1, IDEX_stall=1, PC_hold=0, IFID_hold=0, irq_ack=0, md_busy=0, in_isr=0.
  - Deassertion takes effect at the first clk edge.
- Load-use costs exactly 1 bubble. On the next cycle the load is in MEM and lu is 0.
- mfhi directly behind mult stalls MD_LAT+1 cycles: 1 cycle with EX_md, then MD_LAT cycles with cnt = MD_LAT…1. mfhi issues in the cycle where cnt=0.
- irq_ack is a single-cycle pulse. irq held high in IRQ_SVC produces no further ack.
- After eret, re-entry is possible on the first RUN cycle if irq is still high.
- The in_isr change is visible on the cycle after the accepting or eret edge.
- A reset in the middle of an MD wait clears cnt. md_busy=0 on the first cycle after reset.

## Structure
- Shared package (pipeline_pkg):
  - FSM encoding ST_RUN=1'b0, ST_IRQ_SVC=1'b1
  - default MD_LAT
  - REG_ZERO=5'd0
- One sub-module, md_busy_counter:
  - inputs: clk, reset, load (EX_md)
  - output: busy
  - contains the down-counter of width CNT_W
- The hazard decode and FSM stay in hazard_ctrl.

## Test plan
- lw $5 in EX (EX_MemRd=1, EX_RegWr=1, EX_WrReg=5), ID reads rs=5 → PC_hold=IFID_hold=IDEX_stall=1 for exactly 1 cycle. Same stimulus with EX_WrReg=0 → no stall.
- MD_LAT=4, mult in EX, mfhi in ID → stall for 5 cycles, release on the 6th; md_busy falls together with the stall.
- Load-use stall coincident with EX_branch=1 → IFID_flush=1, IDEX_stall=1, PC_hold=0. ID_jump under stall → no flush until the stall cycle ends.
- irq=1 with ID_valid=1 in RUN → 1-cycle irq_ack, in_isr=1 next cycle. irq held high for 10 cycles → no second ack. ID_eret → in_isr=0, then re-ack on the next RUN cycle.
- irq=1 during an mfhi stall or EX_branch → no ack until stall=0 and EX_branch=0.
- Reset pulled low at cnt=3 while in IRQ_SVC → immediately IFID_flush=IDEX_stall=1 and in_isr=0. After release: md_busy=0, FSM=RUN.
